// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART2BUS internal-bus arbiter.
// The optional tenure timeout is enabled with the UART_ARB_TIMEOUT_EN macro.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int UART_ARB_NUM_REQ  = 4;
    localparam int UART_ARB_MAX_HOLD = 256;

    // Never returns 0, so a 2-entry index or counter still gets one bit.
    function automatic int owner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: rotate requests so the search starts at
// last_owner+1, take the lowest set bit, then rotate the index back.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = UART_ARB_NUM_REQ,
    parameter int IDW     = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_owner,
    output logic [IDW-1:0]     winner,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDW-1:0]       start;
    logic [IDW-1:0]       offset;
    logic [IDW:0]         sum;
    logic                 found;

    always_comb begin
        start  = (last_owner == IDW'(NUM_REQ - 1)) ? '0 : last_owner + 1'b1;
        dbl    = {req, req} >> start;
        rot    = dbl[NUM_REQ-1:0];
        offset = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                offset = IDW'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= (IDW + 1)'(NUM_REQ))
            winner = IDW'(sum - (IDW + 1)'(NUM_REQ));
        else
            winner = sum[IDW-1:0];
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin internal-bus arbiter with registered one-hot grant and a
// one-cycle turnaround between owners; UART_ARB_TIMEOUT_EN bounds tenure.
module uart_bus_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = UART_ARB_NUM_REQ,
    parameter int MAX_HOLD = UART_ARB_MAX_HOLD
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               int_req,
    output logic [NUM_REQ-1:0]               int_gnt,
    output logic                             gnt_valid,
    output logic [owner_width(NUM_REQ)-1:0]  gnt_id,
    output logic                             timeout_pulse,
    output logic [1:0]                       dbg_state
);

    localparam int IDW = owner_width(NUM_REQ);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_GRANT   = GRANT;
    localparam logic [1:0] ST_RELEASE = RELEASE;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [1:0]     state;
    logic [IDW-1:0] last_owner;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic           force_rel;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
        .req        (int_req),
        .last_owner (last_owner),
        .winner     (winner),
        .any_req    (any_req)
    );

    // IDLE and RELEASE arbitrate identically; RELEASE only differs in that
    // the grant was already low for the turnaround cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_owner <= IDW'(NUM_REQ - 1);
            int_gnt    <= '0;
            gnt_valid  <= 1'b0;
            gnt_id     <= '0;
        end else begin
            case (state)
                ST_GRANT: begin
                    if (!int_req[gnt_id] || force_rel) begin
                        int_gnt   <= '0;
                        gnt_valid <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end
                default: begin
                    if (any_req) begin
                        int_gnt    <= ONE_HOT0 << winner;
                        gnt_valid  <= 1'b1;
                        gnt_id     <= winner;
                        last_owner <= winner;
                        state      <= ST_GRANT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int HW = owner_width(MAX_HOLD);

    logic [HW-1:0] hold_cnt;

    assign force_rel = (state == ST_GRANT) && int_req[gnt_id] &&
                       (hold_cnt == HW'(MAX_HOLD - 1));

    // Counter sits at zero outside GRANT, so every new grant starts fresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= force_rel;
            if (state != ST_GRANT)
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign force_rel     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (MAX_HOLD >= 2);
            assert ($onehot0(int_gnt));
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed and randomized bench for uart_bus_arbiter against a cycle-level
// ownership model; honours UART_ARB_TIMEOUT_EN with MAX_HOLD=8.
module tb_uart_bus_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 8;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clock;
    logic               reset;
    logic [NUM_REQ-1:0] int_req;
    logic [NUM_REQ-1:0] int_gnt;
    logic               gnt_valid;
    logic [1:0]         gnt_id;
    logic               timeout_pulse;
    logic [1:0]         dbg_state;

    uart_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clock         (clock),
        .reset         (reset),
        .int_req       (int_req),
        .int_gnt       (int_gnt),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id),
        .timeout_pulse (timeout_pulse),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: who owns the bus, for how long, who went last
    int m_owner;
    int m_last;
    int m_id;
    int m_tenure;
    bit m_to;

    int n_assert = 0;
    int n_fail   = 0;

    // grant-order scoreboard
    logic [1:0] exp_q[$];
    bit         track_order = 1'b0;
    bit         prev_valid  = 1'b0;

    task automatic model_edge(input logic [NUM_REQ-1:0] r, input bit rst);
        if (rst) begin
            m_owner  = -1;
            m_last   = NUM_REQ - 1;
            m_id     = 0;
            m_tenure = 0;
            m_to     = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_tenure == MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_tenure++;
            end
        end else if (r != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (m_owner < 0 && r[c]) m_owner = c;
            end
            m_last   = m_owner;
            m_id     = m_owner;
            m_tenure = 1;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_REQ-1:0] exp_gnt;
        logic [1:0]         exp_id;
        exp_gnt = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
        exp_id  = 2'(m_id);
        n_assert++;
        assert (int_gnt === exp_gnt) else begin
            n_fail++;
            $error("FAIL int_gnt obs=%b exp=%b t=%0t", int_gnt, exp_gnt, $time);
        end
        n_assert++;
        assert (gnt_valid === (m_owner >= 0)) else begin
            n_fail++;
            $error("FAIL gnt_valid obs=%b exp=%b t=%0t", gnt_valid, (m_owner >= 0), $time);
        end
        n_assert++;
        assert (gnt_id === exp_id) else begin
            n_fail++;
            $error("FAIL gnt_id obs=%0d exp=%0d t=%0t", gnt_id, exp_id, $time);
        end
        n_assert++;
        assert (timeout_pulse === m_to) else begin
            n_fail++;
            $error("FAIL timeout_pulse obs=%b exp=%b t=%0t", timeout_pulse, m_to, $time);
        end
        if (track_order && gnt_valid === 1'b1 && !prev_valid) begin
            n_assert++;
            assert (exp_q.size() > 0 && gnt_id === exp_q[0]) else begin
                n_fail++;
                $error("FAIL grant_order obs=%0d exp=%0d", gnt_id,
                       (exp_q.size() > 0) ? int'(exp_q[0]) : -1);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        prev_valid = (gnt_valid === 1'b1);
    endtask

    // driver: apply inputs, take one edge, then check 1 time unit later
    task automatic step(input logic [NUM_REQ-1:0] r, input bit rst);
        int_req = r;
        reset   = rst;
        @(posedge clock);
        model_edge(r, rst);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        step('0, 1'b1);
        step('0, 1'b1);
    endtask

    initial begin
        logic [NUM_REQ-1:0] r;
        int_req = '0;
        reset   = 1'b1;
        model_edge('0, 1'b1);

        // reset state
        do_reset();
        n_assert++;
        assert (dbg_state === 2'(IDLE)) else begin
            n_fail++;
            $error("FAIL reset_state obs=%0d exp=%0d", dbg_state, 2'(IDLE));
        end

        // single requester: grant, drop, turnaround, idle
        step('0, 1'b0);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) step('0, 1'b0);

        // all masters requesting, each leaves after 5 granted cycles
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        track_order = 1'b1;
        for (int i = 0; i < 30; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_tenure >= 5) r[m_owner] = 1'b0;
            step(r, 1'b0);
        end
        track_order = 1'b0;
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL grant_order_left obs=%0d exp=0", exp_q.size());
        end

        // master 2 owns, master 0 requests mid-tenure: no preemption
        do_reset();
        step(4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0101, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);

        // last_owner=0, 0101 -> 2 wins, then 0
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);

        // reset mid-tenure of master 1, then 0010 -> master 1 first
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);

        // master 0 holds, master 1 waits: timeout behaviour depends on build
        do_reset();
        for (int i = 0; i < 30; i++) step(4'b0011, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);

        // randomized traffic with occasional resets
        do_reset();
        r = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NUM_REQ; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            step(r, $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
